// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: AXI4-Stream to UART transmitter with an internal FIFO.
// Bytes accepted on the stream slave are queued and sent LSB first as
// start / DATA_WIDTH data / [parity] / STOP_BITS stop frames on txd.
// Bit period is prescale*8 clk cycles (prescale 0 behaves as 1), latched per frame.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after the data bits.
module uart_tx_buffered #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int STOP_BITS       = 1,
  parameter bit PARITY_ODD      = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic                       txd,
  input  logic                       cts_n,
  input  logic [15:0]                prescale,
  output logic                       busy,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_count
);

  localparam int DEPTH     = 2 ** FIFO_ADDR_WIDTH;
  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT     = (FIFO_ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [BIT_CNT_W-1:0]     LAST_BIT_IDX  = BIT_CNT_W'(DATA_WIDTH - 1);
  // Stop-bit counter preset: one extra period when two stop bits are configured
  localparam logic                     STOP_PRESET   = (STOP_BITS == 2) ? 1'b1 : 1'b0;

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Frame FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0]      r_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   r_count;

  // cts_n synchroniser
  logic r_cts_meta;
  logic r_cts_sync;

  // Transmit datapath
  logic [2:0]            r_state;
  logic [18:0]           r_timer;
  logic [15:0]           r_prescale;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_stop_cnt;
  logic                  r_parity;
  logic                  r_txd;
  logic                  r_busy;

  logic                  w_tready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_can_start;
  logic                  w_bit_done;
  logic                  w_stop_done;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [15:0]           w_presc_in;
  logic [18:0]           w_period_in_m1;
  logic [18:0]           w_period_m1;

  assign w_tready    = (r_count != DEPTH_CNT);
  assign w_push      = s_axis_tvalid && w_tready;
  assign w_can_start = (r_count != '0) && !r_cts_sync;
  assign w_bit_done  = (r_timer == '0);
  assign w_stop_done = (r_state == S_STOP) && w_bit_done && (r_stop_cnt == 1'b0);
  // A frame is launched from IDLE, or straight out of the last stop period
  // so consecutive frames run back-to-back without an idle gap.
  assign w_pop       = w_can_start && ((r_state == S_IDLE) || w_stop_done);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_shift_next = r_shift >> 1;

  // Period for a new frame comes from the live input; a running frame uses
  // the copy latched at launch so prescale changes never stretch it.
  assign w_presc_in     = (prescale == 16'd0) ? 16'd1 : prescale;
  assign w_period_in_m1 = {w_presc_in, 3'b000} - 19'd1;
  assign w_period_m1    = {r_prescale, 3'b000} - 19'd1;

  assign s_axis_tready = w_tready;
  assign txd           = r_txd;
  assign busy          = r_busy;
  assign fifo_count    = r_count;

  // FIFO storage write
  // NOTE: the storage array has no reset; stale words are unreachable because
  // r_count gates every read, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_axis_tdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo depth
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_ADDR_WIDTH'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_ADDR_WIDTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_ADDR_WIDTH + 1)'(1);
        2'b01:   r_count <= r_count - (FIFO_ADDR_WIDTH + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous cts_n pin; resets to "not clear"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= cts_n;
      r_cts_sync <= r_cts_meta;
    end
  end

  // Frame sequencer: launches frames, times each bit and drives the registered txd
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_prescale <= 16'd1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
    end else if (w_pop) begin
      r_shift    <= w_head;
      r_parity   <= (^w_head) ^ PARITY_ODD;
      r_prescale <= w_presc_in;
      r_timer    <= w_period_in_m1;
      r_txd      <= 1'b0;
      r_busy     <= 1'b1;
      r_state    <= S_START;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd  <= 1'b1;
          r_busy <= 1'b0;
        end

        S_START: begin
          if (w_bit_done) begin
            r_txd     <= r_shift[0];
            r_timer   <= w_period_m1;
            r_bit_cnt <= LAST_BIT_IDX;
            r_state   <= S_DATA;
          end else begin
            r_timer <= r_timer - 19'd1;
          end
        end

        S_DATA: begin
          if (w_bit_done) begin
            r_timer <= w_period_m1;
            if (r_bit_cnt == '0) begin
              if (PARITY_EN) begin
                r_txd   <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_txd      <= 1'b1;
                r_stop_cnt <= STOP_PRESET;
                r_state    <= S_STOP;
              end
            end else begin
              r_shift   <= w_shift_next;
              r_txd     <= w_shift_next[0];
              r_bit_cnt <= r_bit_cnt - BIT_CNT_W'(1);
            end
          end else begin
            r_timer <= r_timer - 19'd1;
          end
        end

        S_PARITY: begin
          if (w_bit_done) begin
            r_txd      <= 1'b1;
            r_timer    <= w_period_m1;
            r_stop_cnt <= STOP_PRESET;
            r_state    <= S_STOP;
          end else begin
            r_timer <= r_timer - 19'd1;
          end
        end

        S_STOP: begin
          // Launching the next frame is handled by the w_pop branch above
          if (w_bit_done) begin
            if (r_stop_cnt != 1'b0) begin
              r_stop_cnt <= 1'b0;
              r_timer    <= w_period_m1;
            end else begin
              r_txd   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer - 19'd1;
          end
        end

        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed testbench for uart_tx_buffered (default parameters).
// Parity scenarios run only when UART_TX_PARITY_EN is defined for the build.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       txd;
  logic       cts_n = 1'b0;
  logic [15:0] prescale = 16'd2;
  logic       busy;
  logic [4:0] fifo_count;

  int total = 0;
  int bad   = 0;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic cap [0:4095];

  uart_tx_buffered dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .txd           (txd),
    .cts_n         (cts_n),
    .prescale      (prescale),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one byte; it is accepted on the first edge where tready is high
  task automatic push(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (s_axis_tready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL push_accept: byte %h got tready timeout want accepted", b);
    end else begin
      tick();
    end
    s_axis_tvalid = 1'b0;
  endtask

  // Tick until txd is low (the first start-bit sample), bounded
  task automatic wait_start(output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (txd === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  // Record txd now and after each of the next n-1 edges
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap[i] = txd;
      if (i < n - 1) tick();
    end
  endtask

  // Expected line level for bit k of a frame carrying byte b
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (FB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Number of captured samples deviating from the ideal frame waveform
  function automatic int wave_errors(input logic [7:0] b, input int period, input int base);
    int e;
    e = 0;
    for (int k = 0; k < FB; k++)
      for (int j = 0; j < period; j++)
        if (cap[base + k * period + j] !== frame_bit(b, k)) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cts_n = 1'b0;
    prescale = 16'd2;
    ticks(3);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    rst = 1'b0;
    tick();
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL reset_tready: got %b want 1", s_axis_tready); end
    ticks(3);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_idle_txd: got %b want 1", txd); end
  endtask

  task automatic test_basic();
    int e;
    prescale = 16'd2;
    s_axis_tdata  = 8'hA5;
    s_axis_tvalid = 1'b1;
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL basic_tready: got %b want 1", s_axis_tready); end
    tick();
    s_axis_tvalid = 1'b0;
    total++; if (fifo_count !== 5'd1) begin bad++; $display("FAIL basic_count_e0: got %0d want 1", fifo_count); end
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL basic_txd_e0: got %b want 1", txd); end
    tick();
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL basic_txd_e1: got %b want 0", txd); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_e1: got %b want 1", busy); end
    total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL basic_count_e1: got %0d want 0", fifo_count); end
    capture(FB * 16 + 1);
    e = wave_errors(8'hA5, 16, 0);
    total++; if (e !== 0) begin bad++; $display("FAIL basic_wave_a5: got %0d bad samples want 0", e); end
    total++; if (cap[FB * 16] !== 1'b1) begin bad++; $display("FAIL basic_txd_end: got %b want 1", cap[FB * 16]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_prescale();
    bit to;
    int e;
    prescale = 16'd0;
    push(8'h96);
    wait_start(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL psc0_start: got timeout want start bit"); end
    for (int i = 0; i <= FB * 8; i++) begin
      cap[i] = txd;
      if (i == 20) prescale = 16'd3;
      if (i < FB * 8) tick();
    end
    e = wave_errors(8'h96, 8, 0);
    total++; if (e !== 0) begin bad++; $display("FAIL psc0_wave_96: got %0d bad samples want 0", e); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL psc0_busy_end: got %b want 0", busy); end
    push(8'h4B);
    wait_start(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL psc3_start: got timeout want start bit"); end
    capture(FB * 24 + 1);
    e = wave_errors(8'h4B, 24, 0);
    total++; if (e !== 0) begin bad++; $display("FAIL psc3_wave_4b: got %0d bad samples want 0", e); end
    prescale = 16'd1;
  endtask

  task automatic test_cts();
    bit to;
    bit line_moved;
    int e;
    prescale = 16'd1;
    cts_n = 1'b1;
    ticks(3);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    line_moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (txd !== 1'b1 || busy !== 1'b0) line_moved = 1'b1;
      tick();
    end
    total++; if (line_moved !== 1'b0) begin bad++; $display("FAIL cts_hold_line: got activity want idle"); end
    total++; if (fifo_count !== 5'd3) begin bad++; $display("FAIL cts_hold_count: got %0d want 3", fifo_count); end
    cts_n = 1'b0;
    ticks(2);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL cts_sync_delay: got %b want 1", txd); end
    tick();
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL cts_start_3cyc: got %b want 0", txd); end
    cts_n = 1'b1;
    capture(FB * 8 + 1);
    e = wave_errors(8'h11, 8, 0);
    total++; if (e !== 0) begin bad++; $display("FAIL cts_wave_11: got %0d bad samples want 0", e); end
    line_moved = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (txd !== 1'b1) line_moved = 1'b1;
      tick();
    end
    total++; if (line_moved !== 1'b0) begin bad++; $display("FAIL cts_next_held: got activity want idle"); end
    total++; if (fifo_count !== 5'd2) begin bad++; $display("FAIL cts_held_count: got %0d want 2", fifo_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cts_held_busy: got %b want 0", busy); end
    cts_n = 1'b0;
    wait_start(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL cts_resume: got timeout want start bit"); end
    capture(FB * 16 + 1);
    e = wave_errors(8'h22, 8, 0) + wave_errors(8'h33, 8, FB * 8);
    total++; if (e !== 0) begin bad++; $display("FAIL cts_wave_22_33: got %0d bad samples want 0", e); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int e;
    prescale = 16'd1;
    cts_n = 1'b1;
    ticks(3);
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    s_axis_tdata  = 8'h40;
    s_axis_tvalid = 1'b1;
    ticks(2);
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL b2b_full_tready: got %b want 0", s_axis_tready); end
    total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL b2b_full_count: got %0d want 16", fifo_count); end
    to = 1'b1;
    fork
      begin
        cts_n = 1'b0;
        for (int i = 16; i < 20; i++) push(8'h30 + 8'(i));
      end
      begin
        wait_start(to);
        capture(20 * FB * 8 + 1);
      end
    join
    total++; if (to !== 1'b0) begin bad++; $display("FAIL b2b_start: got timeout want start bit"); end
    for (int f = 0; f < 20; f++) begin
      e = wave_errors(8'h30 + 8'(f), 8, f * FB * 8);
      total++;
      if (e !== 0) begin bad++; $display("FAIL b2b_frame_%0d: got %0d bad samples want 0", f, e); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL b2b_count_end: got %0d want 0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit line_moved;
    int e;
    prescale = 16'd1;
    push(8'h3C);
    wait_start(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL rmid_start: got timeout want start bit"); end
    push(8'h77);
    push(8'h88);
    ticks(18);
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL rmid_pre_txd: got %b want 0", txd); end
    total++; if (fifo_count !== 5'd2) begin bad++; $display("FAIL rmid_pre_count: got %0d want 2", fifo_count); end
    #2 rst = 1'b1;
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rmid_txd: got %b want 1", txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL rmid_count: got %0d want 0", fifo_count); end
    ticks(2);
    rst = 1'b0;
    ticks(3);
    push(8'h5A);
    wait_start(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL rmid_after_start: got timeout want start bit"); end
    capture(FB * 8 + 1);
    e = wave_errors(8'h5A, 8, 0);
    total++; if (e !== 0) begin bad++; $display("FAIL rmid_wave_5a: got %0d bad samples want 0", e); end
    line_moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (txd !== 1'b1) line_moved = 1'b1;
      tick();
    end
    total++; if (line_moved !== 1'b0) begin bad++; $display("FAIL rmid_discarded: got extra frame want idle"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy_end: got %b want 0", busy); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit to;
    int e;
    prescale = 16'd1;
    push(8'h07);
    wait_start(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL par_start_07: got timeout want start bit"); end
    capture(FB * 8 + 1);
    e = wave_errors(8'h07, 8, 0);
    total++; if (e !== 0) begin bad++; $display("FAIL par_wave_07: got %0d bad samples want 0", e); end
    total++; if (cap[76] !== 1'b1) begin bad++; $display("FAIL par_bit_07: got %b want 1", cap[76]); end
    push(8'h03);
    wait_start(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL par_start_03: got timeout want start bit"); end
    capture(FB * 8 + 1);
    e = wave_errors(8'h03, 8, 0);
    total++; if (e !== 0) begin bad++; $display("FAIL par_wave_03: got %0d bad samples want 0", e); end
    total++; if (cap[76] !== 1'b0) begin bad++; $display("FAIL par_bit_03: got %b want 0", cap[76]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_cts();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
